// File: rtl/l2_msg3_ingress_pkg.sv
// Shared L2 message definitions: field widths, msg3 type codes, the packed message
// layout and small decode/arithmetic helpers reused by the message handlers.
package l2_msg3_ingress_pkg;

  localparam int TYPE_W = 8;
  localparam int SRC_W  = 6;
  localparam int TAG_W  = 26;
  localparam int DATA_W = 64;
  localparam int MSG_W  = TYPE_W + SRC_W + TAG_W + DATA_W;

  typedef enum logic [TYPE_W-1:0] {
    LOAD_FWDACK  = 8'h15,
    STORE_FWDACK = 8'h16,
    INV_FWDACK   = 8'h17
  } msg3_type_e;

  typedef struct packed {
    logic [TYPE_W-1:0] mtype;
    logic [SRC_W-1:0]  source;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } l2_msg_t;

  function automatic logic is_legal_msg3_type(input logic [TYPE_W-1:0] t);
    case (t)
      LOAD_FWDACK, STORE_FWDACK, INV_FWDACK: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) return v;
    else            return v + 8'd1;
  endfunction

endpackage

// File: rtl/l2_msg3_ingress_if.sv
// Handshake bundle between the msg3 source, the ingress block and the L2 pipeline.
interface l2_msg3_ingress_if;
  import l2_msg3_ingress_pkg::*;

  logic              msg3_valid;
  logic              msg3_ready;
  logic [TYPE_W-1:0] msg3_type;
  logic [SRC_W-1:0]  msg3_source;
  logic [TAG_W-1:0]  msg3_tag;
  logic [DATA_W-1:0] msg3_data;

  logic              out_valid;
  logic              out_ready;
  logic [TYPE_W-1:0] out_type;
  logic [SRC_W-1:0]  out_source;
  logic [TAG_W-1:0]  out_tag;
  logic [DATA_W-1:0] out_data;
  logic              out_is_store_fwdack;

  modport slave (
    input  msg3_valid, msg3_type, msg3_source, msg3_tag, msg3_data, out_ready,
    output msg3_ready, out_valid, out_type, out_source, out_tag, out_data,
           out_is_store_fwdack
  );

  modport master (
    output msg3_valid, msg3_type, msg3_source, msg3_tag, msg3_data, out_ready,
    input  msg3_ready, out_valid, out_type, out_source, out_tag, out_data,
           out_is_store_fwdack
  );
endinterface

// File: rtl/l2_msg3_ingress_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with valid/ready on both sides; ready is
// derived from registered occupancy only, so a full FIFO frees its slot one cycle late.
module l2_msg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 104
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_s, pop_s;

  assign in_ready_o  = rst_n && (count_q < FULL_CNT);
  assign out_valid_o = (count_q != {CW{1'b0}});
  assign out_data_o  = mem_q[rd_ptr_q];
  assign push_s      = in_valid_i && in_ready_o;
  assign pop_s       = out_valid_o && out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) wr_ptr_d = wr_ptr_q + AW'(1);
    else        wr_ptr_d = wr_ptr_q;
    if (pop_s)  rd_ptr_d = rd_ptr_q + AW'(1);
    else        rd_ptr_d = rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is deliberately not reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= in_data_i;
  end

endmodule

// File: rtl/l2_msg3_ingress.sv
// msg3 ingress: filters illegal message types, queues legal ones in order toward the
// L2 pipeline and keeps saturating counters of dropped messages and STORE_FWDACKs.
module l2_msg3_ingress
  import l2_msg3_ingress_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  l2_msg3_ingress_if.slave        msg,
  output logic                    err_illegal,
  output logic [7:0]              fwdack_count,
  output logic [7:0]              err_count
);
  l2_msg_t          in_msg_s;
  l2_msg_t          head_s;
  logic [MSG_W-1:0] head_bits_s;
  logic             legal_s, push_ready_s, head_valid_s, accept_s, pop_s;
  logic             err_illegal_q, err_illegal_d;
  logic [7:0]       fwd_cnt_q, fwd_cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  assign in_msg_s = '{mtype: msg.msg3_type, source: msg.msg3_source,
                      tag: msg.msg3_tag, data: msg.msg3_data};
  assign legal_s  = is_legal_msg3_type(msg.msg3_type);
  assign accept_s = msg.msg3_valid && push_ready_s;
  assign pop_s    = head_valid_s && msg.out_ready;
  assign head_s   = l2_msg_t'(head_bits_s);

  // Illegal messages are still handshaken but never reach the FIFO write port.
  l2_msg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (MSG_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (msg.msg3_valid && legal_s),
    .in_ready_o  (push_ready_s),
    .in_data_i   (in_msg_s),
    .out_valid_o (head_valid_s),
    .out_ready_i (msg.out_ready),
    .out_data_o  (head_bits_s)
  );

  assign msg.msg3_ready          = push_ready_s;
  assign msg.out_valid           = head_valid_s;
  assign msg.out_type            = head_s.mtype;
  assign msg.out_source          = head_s.source;
  assign msg.out_tag             = head_s.tag;
  assign msg.out_data            = head_s.data;
  assign msg.out_is_store_fwdack = (head_s.mtype == STORE_FWDACK);

  always_comb begin
    err_illegal_d = accept_s && !legal_s;
    err_cnt_d     = err_cnt_q;
    fwd_cnt_d     = fwd_cnt_q;
    if (err_illegal_d) err_cnt_d = sat_inc8(err_cnt_q);
    else               err_cnt_d = err_cnt_q;
    if (pop_s && (head_s.mtype == STORE_FWDACK)) fwd_cnt_d = sat_inc8(fwd_cnt_q);
    else                                          fwd_cnt_d = fwd_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_illegal_q <= 1'b0;
      err_cnt_q     <= 8'd0;
      fwd_cnt_q     <= 8'd0;
    end else begin
      err_illegal_q <= err_illegal_d;
      err_cnt_q     <= err_cnt_d;
      fwd_cnt_q     <= fwd_cnt_d;
    end
  end

  assign err_illegal  = err_illegal_q;
  assign err_count    = err_cnt_q;
  assign fwdack_count = fwd_cnt_q;

endmodule

// File: tb/tb_l2_msg3_ingress.sv
// Randomized self-checking bench for l2_msg3_ingress against a queue-based model.
module tb_l2_msg3_ingress;
  import l2_msg3_ingress_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       err_illegal;
  logic [7:0] fwdack_count, err_count;

  always #5 clk = ~clk;

  l2_msg3_ingress_if bus();

  l2_msg3_ingress #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .msg          (bus),
    .err_illegal  (err_illegal),
    .fwdack_count (fwdack_count),
    .err_count    (err_count)
  );

  typedef struct {
    logic [7:0]  t;
    logic [5:0]  s;
    logic [25:0] g;
    logic [63:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [25:0] otags[$];
  int unsigned m_fwd = 0, m_err = 0;
  bit          m_pulse = 1'b0;
  int          checks = 0, errors = 0;
  bit          chk_en = 1'b0;
  int          n_acc = 0, n_pop = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at t=%0t", tag, $time);
  endtask

  task automatic set_msg(input logic [7:0] t, input logic [5:0] s, input logic [25:0] g,
                         input logic [63:0] d);
    bus.msg3_type   = t;
    bus.msg3_source = s;
    bus.msg3_tag    = g;
    bus.msg3_data   = d;
  endtask

  task automatic rand_msg();
    logic [7:0] t;
    int unsigned r;
    r = $urandom_range(0, 4);
    if (r == 0)      t = 8'h15;
    else if (r == 1) t = 8'h16;
    else if (r == 2) t = 8'h17;
    else             t = 8'($urandom);
    set_msg(t, 6'($urandom), 26'($urandom), {$urandom, $urandom});
  endtask

  // One clock cycle: compare outputs against the model, then advance the model.
  task automatic cycle();
    bit   exp_ready, exp_valid, acc, pop, legal, obs_acc, obs_pop;
    ent_t e;
    #1;
    exp_ready = rst_n && (mq.size() < DEPTH);
    exp_valid = (mq.size() != 0);
    obs_acc   = bus.msg3_valid && bus.msg3_ready;
    obs_pop   = bus.out_valid && bus.out_ready;
    if (chk_en) begin
      check_eq("msg3_ready", bus.msg3_ready, exp_ready);
      check_eq("out_valid", bus.out_valid, exp_valid);
      check_eq("err_illegal", err_illegal, m_pulse);
      check_eq("fwdack_count", fwdack_count, 64'(m_fwd));
      check_eq("err_count", err_count, 64'(m_err));
      if (exp_valid) begin
        check_eq("out_type", bus.out_type, mq[0].t);
        check_eq("out_source", bus.out_source, mq[0].s);
        check_eq("out_tag", bus.out_tag, mq[0].g);
        check_eq("out_data", bus.out_data, mq[0].d);
        check_eq("out_is_store_fwdack", bus.out_is_store_fwdack, mq[0].t == 8'h16);
      end
    end
    acc   = bus.msg3_valid && exp_ready;
    legal = (bus.msg3_type == 8'h15) || (bus.msg3_type == 8'h16) || (bus.msg3_type == 8'h17);
    pop   = exp_valid && bus.out_ready;
    e     = '{t: bus.msg3_type, s: bus.msg3_source, g: bus.msg3_tag, d: bus.msg3_data};
    if (obs_pop) otags.push_back(bus.out_tag);
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_fwd   = 0;
      m_err   = 0;
      m_pulse = 1'b0;
    end else begin
      m_pulse = acc && !legal;
      if (pop) begin
        if (mq[0].t == 8'h16 && m_fwd < 255) m_fwd++;
        void'(mq.pop_front());
      end
      if (acc && legal) mq.push_back(e);
      if (acc && !legal && m_err < 255) m_err++;
    end
    if (obs_acc) n_acc++;
    if (obs_pop) n_pop++;
    @(negedge clk);
  endtask

  task automatic drain();
    bus.msg3_valid = 1'b0;
    bus.out_ready  = 1'b1;
    repeat (DEPTH + 2) cycle();
  endtask

  initial begin
    int acc0, pop0, guard;
    rst_n          = 1'b0;
    bus.msg3_valid = 1'b0;
    bus.out_ready  = 1'b0;
    set_msg(8'h00, 6'h0, 26'h0, 64'h0);
    cycle();
    chk_en = 1'b1;
    cycle();
    check_eq("reset_fwd", fwdack_count, 8'd0);
    check_eq("reset_err", err_count, 8'd0);
    rst_n = 1'b1;
    cycle();

    // Single STORE_FWDACK with out_ready high.
    bus.out_ready  = 1'b1;
    bus.msg3_valid = 1'b1;
    set_msg(8'h16, 6'h1, 26'h3, 64'hDEAD);
    cycle();
    bus.msg3_valid = 1'b0;
    check_eq("single_valid", bus.out_valid, 1'b1);
    check_eq("single_tag", bus.out_tag, 26'h3);
    check_eq("single_is_sf", bus.out_is_store_fwdack, 1'b1);
    cycle();
    check_eq("single_fwd", fwdack_count, 8'd1);

    // Illegal type.
    bus.msg3_valid = 1'b1;
    set_msg(8'h02, 6'h2, 26'h7, 64'h1234);
    cycle();
    bus.msg3_valid = 1'b0;
    check_eq("illegal_pulse", err_illegal, 1'b1);
    check_eq("illegal_no_valid", bus.out_valid, 1'b0);
    cycle();
    check_eq("illegal_pulse_end", err_illegal, 1'b0);
    check_eq("illegal_count", err_count, 8'd1);

    // Fill: four accepted, fifth held off until a slot is freed.
    otags.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_msg(8'h15 + 8'(i % 3), 6'(i), 26'(100 + i), 64'(i * 7));
      bus.msg3_valid = 1'b1;
      if (i < 4) begin
        cycle();
      end else begin
        repeat (3) begin
          cycle();
          check_eq("fill_hold", bus.msg3_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        guard = 0;
        acc0 = n_acc;
        while (n_acc == acc0 && guard < 10) begin
          cycle();
          guard++;
        end
        if (n_acc == acc0) timeout("fill_fifth_accept");
      end
    end
    bus.msg3_valid = 1'b0;
    repeat (DEPTH + 2) cycle();
    check_eq("fill_count", otags.size(), 5);
    for (int i = 0; i < 5 && i < otags.size(); i++)
      check_eq("fill_order", otags[i], 26'(100 + i));

    // Saturation: 300 STORE_FWDACKs dequeued.
    bus.out_ready  = 1'b1;
    bus.msg3_valid = 1'b1;
    pop0  = n_pop;
    guard = 0;
    while ((n_pop - pop0) < 300 && guard < 400) begin
      set_msg(8'h16, 6'($urandom), 26'($urandom), {$urandom, $urandom});
      cycle();
      guard++;
    end
    if ((n_pop - pop0) < 300) timeout("sat_pops");
    drain();
    check_eq("fwd_saturated", fwdack_count, 8'd255);

    // Streaming at occupancy 1.
    bus.out_ready  = 1'b0;
    bus.msg3_valid = 1'b1;
    rand_msg();
    set_msg(8'h17, bus.msg3_source, bus.msg3_tag, bus.msg3_data);
    cycle();
    bus.out_ready = 1'b1;
    acc0 = n_acc;
    pop0 = n_pop;
    for (int i = 0; i < 20; i++) begin
      set_msg(8'h15 + 8'($urandom_range(0, 2)), 6'($urandom), 26'($urandom), {$urandom, $urandom});
      cycle();
      check_eq("stream_valid", bus.out_valid, 1'b1);
    end
    check_eq("stream_acc", n_acc - acc0, 20);
    check_eq("stream_pop", n_pop - pop0, 20);
    drain();

    // Reset with three entries queued.
    bus.out_ready  = 1'b0;
    bus.msg3_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_msg(8'h16, 6'(i), 26'(200 + i), 64'(i));
      cycle();
    end
    bus.msg3_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_fwd", fwdack_count, 8'd0);
    check_eq("rst_err", err_count, 8'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    pop0 = n_pop;
    repeat (6) cycle();
    check_eq("rst_no_stale", n_pop - pop0, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rst_n          = ($urandom_range(0, 199) != 0);
      bus.msg3_valid = $urandom_range(0, 2) != 0;
      bus.out_ready  = $urandom_range(0, 2) != 0;
      rand_msg();
      cycle();
    end
    rst_n = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_msg3_ingress.md
L2_MSG3_INGRESS -- requirements
Module: l2_msg3_ingress

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the FIFO entry count; it is a power of two and at least 2.
REQ-002 SHALL have port clk, input, 1 bit, the single clock.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port msg3_valid, input, 1 bit, upstream message valid.
REQ-005 SHALL have port msg3_ready, output, 1 bit, block can accept a message.
REQ-006 SHALL have ports msg3_type (input, 8 bits), msg3_source (input, 6 bits), msg3_tag (input, 26 bits) and msg3_data (input, 64 bits), the message fields.
REQ-007 SHALL have port out_valid, output, 1 bit, head entry present toward the L2 pipeline.
REQ-008 SHALL have port out_ready, input, 1 bit, the pipeline consumes the head this cycle.
REQ-009 SHALL have ports out_type (8 bits), out_source (6 bits), out_tag (26 bits) and out_data (64 bits), all outputs, the head-entry fields.
REQ-010 SHALL have port out_is_store_fwdack, output, 1 bit, set when out_type equals STORE_FWDACK (8'h16).
REQ-011 SHALL have port err_illegal, output, 1 bit, a one-cycle pulse for a dropped illegal type.
REQ-012 SHALL have port fwdack_count, output, 8 bits, count of STORE_FWDACKs dequeued, saturating.
REQ-013 SHALL have port err_count, output, 8 bits, count of illegal messages dropped, saturating.

Function
REQ-014 SHALL treat exactly three type codes as legal: LOAD_FWDACK 8'h15, STORE_FWDACK 8'h16 and INV_FWDACK 8'h17.
REQ-015 SHALL assert msg3_ready iff rst_n is high and occupancy is less than DEPTH; this is combinational from registered occupancy only, not from out_ready.
REQ-016 SHALL accept a message on a cycle where msg3_valid and msg3_ready are both high.
REQ-017 SHALL write an accepted legal message into the tail entry and increment occupancy.
REQ-018 SHALL discard an accepted illegal message with no entry written, pulse err_illegal on the next cycle and increment err_count (saturating at 255).
REQ-019 SHALL make an enqueue visible at the head no earlier than the next cycle; there is no combinational valid-to-out path, and the minimum latency is 1 cycle.
REQ-020 SHALL drive out_valid equal to (occupancy is not zero), and drive the out_* fields from the head entry.
REQ-021 SHALL hold the out_* fields stable while out_valid is high and out_ready is low.
REQ-022 SHALL dequeue the head on a cycle where out_valid and out_ready are both high.
REQ-023 SHALL increment fwdack_count when the dequeued entry is STORE_FWDACK; the count saturates at 255 and does not wrap.
REQ-024 SHALL, on a simultaneous enqueue and dequeue, leave occupancy unchanged and advance both pointers.
REQ-025 SHALL keep read and write pointers log2(DEPTH) bits wide, wrapping modulo DEPTH, with occupancy log2(DEPTH)+1 bits.
REQ-026 SHALL, when full, hold msg3_ready low even if out_ready is high that cycle; the freed slot is offered on the next cycle.
REQ-027 SHALL, when empty, ignore out_ready; no dequeue occurs and the counters do not change.
REQ-028 SHALL never alter entry order: dequeue order equals the order of accepted legal messages.

Reset
REQ-029 SHALL, while rst_n is low, set occupancy and both pointers to 0 and drive out_valid 0, msg3_ready 0, err_illegal 0, fwdack_count 0 and err_count 0.
REQ-030 SHALL, on reset mid-operation, flush all entries so none are delivered after reset release; entry data storage need not be cleared.
REQ-031 SHALL raise msg3_ready on the first cycle after rst_n is sampled high.

Structure
REQ-032 SHALL take the type codes (8'h15, 8'h16, 8'h17) and the field widths (8, 6, 26 and 64) from the shared L2 message package.
REQ-033 SHALL put a legal-type decode function in the same package for reuse by the STORE_FWDACK and other message handlers.
REQ-034 SHALL instantiate exactly one sub-module, l2_msg_fifo: a generic DEPTH x 104-bit synchronous FIFO with valid/ready on both sides.

Verification
REQ-035 SHALL cover single message: enqueue type 8'h16, tag 26'h3, data 64'hDEAD with out_ready high -> out_valid high exactly 1 cycle later, out_is_store_fwdack 1, fwdack_count 1.
REQ-036 SHALL cover fill: hold out_ready low and offer 5 legal messages with DEPTH 4 -> msg3_ready goes low after the 4th, the 5th is held off, and raising out_ready delivers all 5 in order.
REQ-037 SHALL cover illegal type: enqueue type 8'h02 -> no out_valid, err_illegal pulses 1 cycle, err_count 1.
REQ-038 SHALL cover saturation: dequeue 300 STORE_FWDACKs -> fwdack_count holds at 255.
REQ-039 SHALL cover streaming: hold valid and ready both high for 20 cycles with occupancy at 1 -> one enqueue and one dequeue per cycle, occupancy constant.
REQ-040 SHALL cover reset mid-operation: assert rst_n low for 1 cycle with 3 entries queued -> out_valid 0, counters 0, and no stale entry emitted after release.
